alu_issue_ctrl: RTL
===================

Name: alu_issue_ctrl

Overview:
Initiator side of the ALU interface. Accepts one decoded instruction per valid/ready handshake, maps opcode/funct to the 4-bit ALU control code, and drives src1/src2/alu_control to the combinational ALU. It waits a fixed settle time, registers result/zero, and returns them to the execute stage over a valid/ready handshake. It sits between the control unit's decode output and the ALU.

Parameters:
WIDTH, 32, datapath width of operands and result
ALU_LAT, 1, cycles alu_* are held before capture (legal 1..15)

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  synchronous, active-high reset
in_valid  in  1  instruction request valid
in_ready  out  1  block can accept a request
in_opcode  in  7  RISC-V opcode
in_funct3  in  3  funct3
in_funct7  in  7  funct7
in_rs1_data  in  WIDTH  operand 1
in_rs2_data  in  WIDTH  operand 2 (R-type, branch)
in_imm  in  WIDTH  sign-extended immediate (I-type)
alu_src1  out  WIDTH  registered ALU operand 1
alu_src2  out  WIDTH  registered ALU operand 2
alu_control  out  4  registered ALU op code
alu_result  in  WIDTH  ALU result (combinational from alu_*)
alu_zero  in  1  ALU zero flag
out_valid  out  1  response valid
out_ready  in  1  consumer accepts response
out_result  out  WIDTH  captured result
out_zero  out  1  captured zero flag
out_branch_taken  out  1  branch decision (branch ops only, else 0)
out_illegal  out  1  unsupported encoding
out_div_by_zero  out  1  DIV with operand 2 == 0

Behaviour:
- Interface: one clock clk; reset rst is synchronous and active-high.
- ALU codes: AND 0000, OR 0001, ADD 0010, SUB 0110, SLT 0111, MUL 1000, DIV 1001.
- Decode, opcode 0110011 (R): f7=0000000 with f3 000/111/110/010 -> ADD/AND/OR/SLT; f7=0100000 with f3 000 -> SUB; f7=0000001 with f3 000 -> MUL, f3 100 -> DIV; src2=rs2.
- Decode, opcode 0010011 (I): f3 000/111/110/010 -> ADD/AND/OR/SLT; src2=imm; funct7 ignored.
- Decode, opcode 1100011 (branch): f3 000 BEQ, 001 BNE -> SUB; taken = zero (BEQ) or ~zero (BNE).
- Any other opcode/funct combination is illegal.
- FSM states: IDLE, EXEC, DONE.
  - IDLE: in_ready=1. Accept on in_valid&in_ready.
    - Legal, non-div0: load alu_src1/src2/control, counter=ALU_LAT-1, go EXEC.
    - Illegal: go DONE with out_result=0, out_zero=0, out_illegal=1; ALU not driven.
    - DIV with src2==0: go DONE with out_result=all-ones, out_zero=0, out_div_by_zero=1; ALU not driven.
  - EXEC: in_ready=0; alu_* held stable. Counter decrements each cycle. At counter==0 capture alu_result/alu_zero, compute branch_taken, go DONE.
  - DONE: out_valid=1; out_* stable until out_valid&out_ready, then IDLE. Holds indefinitely under backpressure.
- Latency: accept edge T -> out_valid high ALU_LAT+1 cycles later (ALU_LAT=1: 2 cycles). Illegal/div0: 1 cycle.
- No overlap: next accept occurs no earlier than the cycle after the response handshake. Throughput is 1 op per ALU_LAT+2 cycles with out_ready held high.
- alu_* retain their last issued values while idle.
- Reset values: in_ready=0 while rst is asserted, 1 in the first IDLE cycle after it. All other outputs and alu_* reset to 0, counter 0, state IDLE.
- rst mid-EXEC or mid-DONE: the in-flight op is discarded, no out_valid is produced, and rst dominates a simultaneous handshake.
- Width: no arithmetic in this block except the div0 compare (in_rs2_data==0) and the counter; result passes through unchanged.

Decomposition:
- Package alu_pkg: ALU op code localparams, opcode/funct3/funct7 constants, FSM state encoding.
- Sub-module alu_op_decoder (combinational): opcode/funct3/funct7 -> alu_control, use_imm, is_branch, is_bne, is_div, illegal. The FSM and registers live in alu_issue_ctrl.

Test Plan:
- ADD R-type rs1=15, rs2=5, ALU_LAT=1 -> alu_control=0010; out_valid 2 cycles after accept; out_result=20, out_zero=0.
- Back-to-back ops, each on 15 and 5, out_ready high: SUB -> 10 (0110), MUL -> 75 (1000), DIV -> 3 (1001), ADDI imm=-5 -> 10. Each response is accepted before the next op is accepted.
- BEQ rs1=10, rs2=10 -> out_zero=1, out_branch_taken=1. BNE with the same operands -> taken=0. BNE with 20, 4 -> out_result=16, taken=1.
- DIV 15/0 -> out_valid 1 cycle after accept; out_result=FFFFFFFF, out_div_by_zero=1; alu_control unchanged from the previous op. Opcode 1111111 -> out_illegal=1, out_result=0.
- Backpressure, ALU_LAT=3: out_ready low 5 cycles -> out_valid and out_* stable; in_ready=0 throughout; handshake returns to IDLE.
- rst for 1 cycle during EXEC of MUL -> next cycle in IDLE, all outputs 0, no out_valid. A following ADD 20+4 -> 24.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared constants for the ALU issue controller: ALU codes, RISC-V encodings,
// FSM states and the decode bundle passed from the decoder to the issue FSM.
package alu_pkg;

  localparam int unsigned CTRL_W = 4;
  localparam int unsigned CNT_W  = 4;

  localparam logic [CTRL_W-1:0] ALU_AND = 4'b0000;
  localparam logic [CTRL_W-1:0] ALU_OR  = 4'b0001;
  localparam logic [CTRL_W-1:0] ALU_ADD = 4'b0010;
  localparam logic [CTRL_W-1:0] ALU_SUB = 4'b0110;
  localparam logic [CTRL_W-1:0] ALU_SLT = 4'b0111;
  localparam logic [CTRL_W-1:0] ALU_MUL = 4'b1000;
  localparam logic [CTRL_W-1:0] ALU_DIV = 4'b1001;

  localparam logic [6:0] OPC_R = 7'b0110011;
  localparam logic [6:0] OPC_I = 7'b0010011;
  localparam logic [6:0] OPC_B = 7'b1100011;

  localparam logic [2:0] F3_ADD = 3'b000;
  localparam logic [2:0] F3_AND = 3'b111;
  localparam logic [2:0] F3_OR  = 3'b110;
  localparam logic [2:0] F3_SLT = 3'b010;
  localparam logic [2:0] F3_DIV = 3'b100;
  localparam logic [2:0] F3_BEQ = 3'b000;
  localparam logic [2:0] F3_BNE = 3'b001;

  localparam logic [6:0] F7_BASE   = 7'b0000000;
  localparam logic [6:0] F7_ALT    = 7'b0100000;
  localparam logic [6:0] F7_MULDIV = 7'b0000001;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  typedef struct packed {
    logic [CTRL_W-1:0] alu_control;
    logic              use_imm;
    logic              is_branch;
    logic              is_bne;
    logic              is_div;
    logic              illegal;
  } dec_t;

  // A legal decode with every qualifier cleared; callers set the flags they need.
  function automatic dec_t mk_dec(input logic [CTRL_W-1:0] ctrl);
    dec_t d;
    d             = '0;
    d.alu_control = ctrl;
    return d;
  endfunction

endpackage

// File: rtl/alu_op_decoder.sv
// Combinational opcode/funct3/funct7 decode into an ALU control code plus
// operand-select and special-case qualifiers.
module alu_op_decoder
  import alu_pkg::*;
(
  input  logic [6:0] opcode_i,
  input  logic [2:0] funct3_i,
  input  logic [6:0] funct7_i,
  output dec_t       dec_c
);

  always_comb begin
    dec_c         = '0;
    dec_c.illegal = 1'b1;
    case (opcode_i)
      OPC_R: begin
        case ({funct7_i, funct3_i})
          {F7_BASE, F3_ADD}:   dec_c = mk_dec(ALU_ADD);
          {F7_BASE, F3_AND}:   dec_c = mk_dec(ALU_AND);
          {F7_BASE, F3_OR}:    dec_c = mk_dec(ALU_OR);
          {F7_BASE, F3_SLT}:   dec_c = mk_dec(ALU_SLT);
          {F7_ALT, F3_ADD}:    dec_c = mk_dec(ALU_SUB);
          {F7_MULDIV, F3_ADD}: dec_c = mk_dec(ALU_MUL);
          {F7_MULDIV, F3_DIV}: begin
            dec_c        = mk_dec(ALU_DIV);
            dec_c.is_div = 1'b1;
          end
          default: ;
        endcase
      end
      // funct7 carries immediate bits here, so it plays no part in the decode
      OPC_I: begin
        case (funct3_i)
          F3_ADD:  dec_c = mk_dec(ALU_ADD);
          F3_AND:  dec_c = mk_dec(ALU_AND);
          F3_OR:   dec_c = mk_dec(ALU_OR);
          F3_SLT:  dec_c = mk_dec(ALU_SLT);
          default: ;
        endcase
        if (!dec_c.illegal) dec_c.use_imm = 1'b1;
      end
      OPC_B: begin
        if (funct3_i == F3_BEQ || funct3_i == F3_BNE) begin
          dec_c           = mk_dec(ALU_SUB);
          dec_c.is_branch = 1'b1;
          dec_c.is_bne    = (funct3_i == F3_BNE);
        end
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/alu_issue_ctrl.sv
// Issues one decoded instruction at a time to a combinational ALU, waits a
// fixed settle time, and returns the captured result over valid/ready.
module alu_issue_ctrl
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned ALU_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [6:0]        in_opcode,
  input  logic [2:0]        in_funct3,
  input  logic [6:0]        in_funct7,
  input  logic [WIDTH-1:0]  in_rs1_data,
  input  logic [WIDTH-1:0]  in_rs2_data,
  input  logic [WIDTH-1:0]  in_imm,
  output logic [WIDTH-1:0]  alu_src1,
  output logic [WIDTH-1:0]  alu_src2,
  output logic [CTRL_W-1:0] alu_control,
  input  logic [WIDTH-1:0]  alu_result,
  input  logic              alu_zero,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WIDTH-1:0]  out_result,
  output logic              out_zero,
  output logic              out_branch_taken,
  output logic              out_illegal,
  output logic              out_div_by_zero
);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   src1_q, src1_d, src2_q, src2_d;
  logic [CTRL_W-1:0]  ctrl_q, ctrl_d;
  logic               in_ready_q, in_ready_d;
  logic               out_valid_q, out_valid_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic               zero_q, zero_d;
  logic               taken_q, taken_d;
  logic               illegal_q, illegal_d;
  logic               div0_q, div0_d;
  logic               is_branch_q, is_branch_d;
  logic               is_bne_q, is_bne_d;

  dec_t               dec_c;
  logic               accept_c;
  logic               div0_c;

  alu_op_decoder u_dec (
    .opcode_i (in_opcode),
    .funct3_i (in_funct3),
    .funct7_i (in_funct7),
    .dec_c    (dec_c)
  );

  assign accept_c = in_valid && in_ready_q;
  assign div0_c   = dec_c.is_div && (in_rs2_data == '0);

  // Next-state and registered-output logic
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    src1_d      = src1_q;
    src2_d      = src2_q;
    ctrl_d      = ctrl_q;
    result_d    = result_q;
    zero_d      = zero_q;
    taken_d     = taken_q;
    illegal_d   = illegal_q;
    div0_d      = div0_q;
    is_branch_d = is_branch_q;
    is_bne_d    = is_bne_q;

    case (state_q)
      ST_IDLE: begin
        if (accept_c) begin
          if (dec_c.illegal) begin
            state_d   = ST_DONE;
            result_d  = '0;
            zero_d    = 1'b0;
            taken_d   = 1'b0;
            illegal_d = 1'b1;
            div0_d    = 1'b0;
          end else if (div0_c) begin
            state_d   = ST_DONE;
            result_d  = '1;
            zero_d    = 1'b0;
            taken_d   = 1'b0;
            illegal_d = 1'b0;
            div0_d    = 1'b1;
          end else begin
            state_d     = ST_EXEC;
            src1_d      = in_rs1_data;
            src2_d      = dec_c.use_imm ? in_imm : in_rs2_data;
            ctrl_d      = dec_c.alu_control;
            is_branch_d = dec_c.is_branch;
            is_bne_d    = dec_c.is_bne;
            cnt_d       = CNT_W'(ALU_LAT - 1);
          end
        end
      end
      ST_EXEC: begin
        if (cnt_q == '0) begin
          state_d   = ST_DONE;
          result_d  = alu_result;
          zero_d    = alu_zero;
          taken_d   = is_branch_q & (alu_zero ^ is_bne_q);
          illegal_d = 1'b0;
          div0_d    = 1'b0;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_DONE: begin
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    in_ready_d  = (state_d == ST_IDLE);
    out_valid_d = (state_d == ST_DONE);
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      src1_q      <= '0;
      src2_q      <= '0;
      ctrl_q      <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      zero_q      <= 1'b0;
      taken_q     <= 1'b0;
      illegal_q   <= 1'b0;
      div0_q      <= 1'b0;
      is_branch_q <= 1'b0;
      is_bne_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      src1_q      <= src1_d;
      src2_q      <= src2_d;
      ctrl_q      <= ctrl_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      result_q    <= result_d;
      zero_q      <= zero_d;
      taken_q     <= taken_d;
      illegal_q   <= illegal_d;
      div0_q      <= div0_d;
      is_branch_q <= is_branch_d;
      is_bne_q    <= is_bne_d;
    end
  end

  assign in_ready         = in_ready_q;
  assign alu_src1         = src1_q;
  assign alu_src2         = src2_q;
  assign alu_control      = ctrl_q;
  assign out_valid        = out_valid_q;
  assign out_result       = result_q;
  assign out_zero         = zero_q;
  assign out_branch_taken = taken_q;
  assign out_illegal      = illegal_q;
  assign out_div_by_zero  = div0_q;

endmodule
